// File: rtl/gift_inv_perm_unit_if.sv
// Byte-wide valid/ready stream used on both sides of the inverse permutation unit.
interface gift_inv_perm_unit_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/gift_inv_perm_unit.sv
// Byte-serial GIFT-64 inverse PermBits: gathers 8 bytes, permutes in one cycle, drains 8 bytes.
// out_valid rises two edges after the 8th accept; drain holds indefinitely while out_ready is low.
module gift_inv_perm_unit #(
  parameter bit LOAD_MSB_FIRST = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        abort,
  gift_inv_perm_unit_if.slave         in_if,
  gift_inv_perm_unit_if.master        out_if,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    PERM  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic [63:0] st_q;
  logic [63:0] st_d;
  logic        done_q;
  logic [2:0]  lane;
  logic        in_hs;
  logic        out_hs;

  // Source bit feeding inverse-permuted bit i: out[i] = st[P(i)].
  function automatic logic [5:0] perm_src(input int i);
    return 6'(4 * (i / 16) + 16 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4));
  endfunction

  always_comb begin
    st_d = '0;
    for (int i = 0; i < 64; i++) begin
      st_d[i] = st_q[perm_src(i)];
    end
  end

  // Reversed lane order is simply the bitwise complement of the 3-bit count.
  assign lane   = LOAD_MSB_FIRST ? ~cnt_q : cnt_q;
  assign cnt_d  = cnt_q + 3'd1;

  assign in_if.ready  = (state_q == LOAD)  && !rst;
  assign out_if.valid = (state_q == DRAIN) && !rst;
  assign out_if.data  = st_q[{lane, 3'b000} +: 8];
  assign busy         = (state_q != LOAD)  && !rst;
  assign done         = done_q;

  assign in_hs  = in_if.valid  && in_if.ready;
  assign out_hs = out_if.valid && out_if.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= 3'd0;
      st_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= LOAD;
        cnt_q   <= 3'd0;
      end else begin
        case (state_q)
          LOAD: begin
            if (in_hs) begin
              st_q[{lane, 3'b000} +: 8] <= in_if.data;
              cnt_q                     <= cnt_d;
              if (cnt_q == 3'd7) state_q <= PERM;
            end
          end
          PERM: begin
            st_q    <= st_d;
            state_q <= DRAIN;
          end
          DRAIN: begin
            if (out_hs) begin
              cnt_q <= cnt_d;
              if (cnt_q == 3'd7) begin
                done_q  <= 1'b1;
                state_q <= LOAD;
              end
            end
          end
          default: begin
            state_q <= LOAD;
            cnt_q   <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/gift_inv_perm_unit.md
Name: gift_inv_perm_unit

Overview:
- Byte-serial GIFT-64 inverse bit-permutation stage in the GIFT decryption ISE datapath.
- Collects eight state bytes into a 64-bit buffer and applies the inverse PermBits in one cycle.
- Streams the permuted state out one byte per handshake directly into the byte-wide inverse S-box (two nibbles per byte).
- Sits immediately upstream of the inverse S-box.

Parameters:
LOAD_MSB_FIRST, 0, 0: first byte accepted/emitted is state[7:0]; 1: first byte is state[63:56] (applies to both load and drain order)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
abort  input  1  synchronous discard of current block, return to LOAD
in_valid  input  1  upstream byte valid
in_ready  output  1  unit can accept a byte
in_data  input  8  state byte in
out_valid  output  1  permuted byte valid
out_ready  input  1  downstream (inverse S-box stage) accepts byte
out_data  output  8  permuted state byte out
busy  output  1  high in PERM or DRAIN
done  output  1  one-cycle pulse when last output byte is accepted

Behaviour:
- States: LOAD, PERM, DRAIN. 3-bit byte counter cnt (0..7), 64-bit buffer st.
- Reset (rst high at clock edge): state=LOAD, cnt=0, st=0, done=0. in_ready=0, out_valid=0, busy=0 while rst is high; in_ready=1 on the first cycle after rst falls.
- rst has priority over abort; abort has priority over all handshakes.
- LOAD: in_ready=1, out_valid=0.
  - On in_valid&&in_ready: byte written to lane cnt (lane k = st[8k+7:8k]; lane 7-k if LOAD_MSB_FIRST); cnt++.
  - Accepting the byte with cnt==7 -> cnt=0, go to PERM.
- PERM (exactly 1 cycle): in_ready=0, out_valid=0.
  - st <= invperm(st), where invperm bit i = st[P(i)].
  - P(i) = 4*floor(i/16) + 16*((3*floor((i mod 16)/4) + (i mod 4)) mod 4) + (i mod 4).
  - Purely bit routing, no arithmetic. Go to DRAIN.
- DRAIN: out_valid=1, in_ready=0, out_data = lane cnt of st (same lane order as load).
  - out_data is stable while out_valid&&!out_ready.
  - On out_ready: cnt++. At cnt==7 handshake: done=1 for that next cycle, cnt=0, go to LOAD.
- Latency: 8th input accepted at edge N -> out_valid high in cycle after edge N+1 (1 PERM cycle). Minimum block period 17 cycles with no backpressure.
- Backpressure: no timeout; DRAIN holds indefinitely while out_ready=0. No input accepted until drain completes; no bypass of LOAD.
- abort in any state: next cycle state=LOAD, cnt=0, out_valid=0, done=0. st is not cleared; stale data is never emitted because every lane is rewritten before the next PERM. A byte presented on in_valid in the abort cycle is discarded.
- rst mid-block: identical to abort, plus st cleared.
- in_valid while in_ready=0: ignored; upstream must hold.
- out_ready while out_valid=0: ignored.

Test Plan:
- Load bytes 00,00,02,00,00,00,00,00 (state 64'h0000_0000_0002_0000, bit 17), out_ready=1 -> drained bytes 02,00,00,00,00,00,00,00 (64'h2, since P(1)=17); done pulses once; cycle count from 8th accept to first out_valid = 2 edges.
- Load 64'h0001_0000_0000_0000 (bit 48) -> output 64'h0000_0000_0000_0010 (P(4)=48). Load 64'h1 -> 64'h1 (P(0)=0). Load all-ones -> all-ones.
- Random 64-bit states (1000 blocks), random in_valid/out_ready gaps -> output equals software inverse PermBits. Feeding output through forward PermBits returns the input. No byte duplicated or dropped.
- Backpressure: hold out_ready=0 for 5 cycles at byte 3 -> out_data stable, cnt frozen, in_ready=0 throughout, done only after byte 7 handshake.
- abort asserted after 4 bytes loaded, then a full new block loaded -> output reflects only the new block; abort during DRAIN at byte 2 -> out_valid=0 next cycle, in_ready=1.
- rst pulse during DRAIN -> in_ready=0 and out_valid=0 during rst; in_ready=1 and busy=0 the cycle after; LOAD_MSB_FIRST=1 build repeats the bit-17 test with reversed byte order.
